// File: rtl/css_syndrome_sequencer.sv
// css_syndrome_sequencer: schedules 5-qubit-code syndrome decoding rounds.
// Optional per-axis statistics are enabled by defining CSS_FB_AXIS_STATS_EN.
module css_syndrome_sequencer #(
  parameter int SETTLE_CYCLES   = 2,
  parameter int CNT_W           = 16,
  parameter int CAPTURE_TIMEOUT = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             syn_valid,
  output logic             syn_ready,
  input  logic [3:0]       syn_data,
  output logic [3:0]       lut_ancilla,
  input  logic [4:0]       lut_correction,
  input  logic [1:0]       lut_axis,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [4:0]       cmd_qubit,
  output logic [1:0]       cmd_axis,
  output logic             round_done,
  output logic             fault,
  output logic [CNT_W-1:0] round_count,
  output logic [CNT_W-1:0] corr_count
`ifdef CSS_FB_AXIS_STATS_EN
  ,
  output logic [CNT_W-1:0] x_count,
  output logic [CNT_W-1:0] y_count,
  output logic [CNT_W-1:0] z_count,
  output logic [3:0]       last_syndrome
`endif
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW =
    (CAPTURE_TIMEOUT > 1) ? $clog2(CAPTURE_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DECIDE,
    ISSUE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] cap_cnt;
  logic [2:0]    flags;
  logic [2:0]    flags_n;
  logic [2:0]    hit;
  logic [2:0]    nz;
  logic [4:0]    cap_x;
  logic [4:0]    cap_y;
  logic [4:0]    cap_z;
  logic [4:0]    q_n;
  logic [1:0]    ax_n;
  logic          accept;
  logic          load_cmd;
  logic          set_fault;
  logic          hs;
  logic          end_round;

  assign syn_ready = (state == IDLE);
  assign cmd_valid = (state == ISSUE);
  assign nz        = {|cap_z, |cap_y, |cap_x};

  always_comb begin
    hit = 3'b000;
    case (lut_axis)
      2'b01:   hit = 3'b001;
      2'b10:   hit = 3'b010;
      2'b11:   hit = 3'b100;
      default: hit = 3'b000;
    endcase
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    load_cmd  = 1'b0;
    q_n       = cap_x;
    ax_n      = 2'b01;
    set_fault = 1'b0;
    hs        = 1'b0;
    end_round = 1'b0;
    flags_n   = flags | hit;
    unique case (state)
      IDLE: begin
        if (syn_valid) begin
          accept  = 1'b1;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) state_n = CAPTURE;
      end
      CAPTURE: begin
        if (&flags_n) begin
          state_n = DECIDE;
        end else if (cap_cnt == TW'(CAPTURE_TIMEOUT - 1)) begin
          set_fault = 1'b1;
          end_round = 1'b1;
          state_n   = IDLE;
        end
      end
      DECIDE: begin
        state_n   = IDLE;
        end_round = 1'b1;
        unique case (nz)
          3'b001: load_cmd = 1'b1;
          3'b010: begin
            q_n      = cap_y;
            ax_n     = 2'b10;
            load_cmd = 1'b1;
          end
          3'b100: begin
            q_n      = cap_z;
            ax_n     = 2'b11;
            load_cmd = 1'b1;
          end
          3'b000:  set_fault = (lut_ancilla != 4'd0);
          default: set_fault = 1'b1;
        endcase
        if (load_cmd) begin
          state_n   = ISSUE;
          end_round = 1'b0;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          hs        = 1'b1;
          end_round = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lut_ancilla <= '0;
      cmd_qubit   <= '0;
      cmd_axis    <= '0;
      round_done  <= 1'b0;
      fault       <= 1'b0;
      round_count <= '0;
      corr_count  <= '0;
      settle_cnt  <= '0;
      cap_cnt     <= '0;
      flags       <= '0;
      cap_x       <= '0;
      cap_y       <= '0;
      cap_z       <= '0;
    end else begin
      round_done <= end_round;
      if (accept) begin
        lut_ancilla <= syn_data;
        round_count <= round_count + CNT_W'(1);
        settle_cnt  <= SW'(SETTLE_CYCLES - 1);
        cap_cnt     <= '0;
        flags       <= '0;
        cap_x       <= '0;
        cap_y       <= '0;
        cap_z       <= '0;
      end
      if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - SW'(1);
      // syndrome is held, so a repeated axis rewrites the same value
      if (state == CAPTURE) begin
        flags   <= flags_n;
        cap_cnt <= cap_cnt + TW'(1);
        if (hit[0]) cap_x <= lut_correction;
        if (hit[1]) cap_y <= lut_correction;
        if (hit[2]) cap_z <= lut_correction;
      end
      if (load_cmd) begin
        cmd_qubit <= q_n;
        cmd_axis  <= ax_n;
      end
      if (set_fault) fault <= 1'b1;
      if (hs) corr_count <= corr_count + CNT_W'(1);
    end
  end

`ifdef CSS_FB_AXIS_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_count       <= '0;
      y_count       <= '0;
      z_count       <= '0;
      last_syndrome <= '0;
    end else begin
      if (accept) last_syndrome <= syn_data;
      if (hs) begin
        if (cmd_axis == 2'b01) x_count <= x_count + CNT_W'(1);
        if (cmd_axis == 2'b10) y_count <= y_count + CNT_W'(1);
        if (cmd_axis == 2'b11) z_count <= z_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_css_syndrome_sequencer.sv
// tb_css_syndrome_sequencer: vector table, corner sequences and random
// rounds against a stabilizer-derived decoder model of the 5-qubit code.
module tb_css_syndrome_sequencer;

  logic        CLK;
  logic        RST;
  logic        syn_valid;
  logic        syn_ready;
  logic [3:0]  syn_data;
  logic [3:0]  lut_ancilla;
  logic [4:0]  lut_correction;
  logic [1:0]  lut_axis;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_qubit;
  logic [1:0]  cmd_axis;
  logic        round_done;
  logic        fault;
  logic [15:0] round_count;
  logic [15:0] corr_count;
`ifdef CSS_FB_AXIS_STATS_EN
  logic [15:0] x_count;
  logic [15:0] y_count;
  logic [15:0] z_count;
  logic [3:0]  last_syndrome;
`endif

  css_syndrome_sequencer dut (
    .CLK            (CLK),
    .RST            (RST),
    .syn_valid      (syn_valid),
    .syn_ready      (syn_ready),
    .syn_data       (syn_data),
    .lut_ancilla    (lut_ancilla),
    .lut_correction (lut_correction),
    .lut_axis       (lut_axis),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_qubit      (cmd_qubit),
    .cmd_axis       (cmd_axis),
    .round_done     (round_done),
    .fault          (fault),
    .round_count    (round_count),
    .corr_count     (corr_count)
`ifdef CSS_FB_AXIS_STATS_EN
    ,
    .x_count        (x_count),
    .y_count        (y_count),
    .z_count        (z_count),
    .last_syndrome  (last_syndrome)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stabilizers g1..g4 (XZZXI and cyclic shifts), 2 bits per qubit:
  // 00 I, 01 X, 10 Y, 11 Z; g1 in the top 10 bits, qubit 1 leftmost.
  localparam logic [39:0] STAB = {
    10'b01_11_11_01_00,
    10'b00_01_11_11_01,
    10'b01_00_01_11_11,
    10'b11_01_00_01_11
  };

  function automatic logic [3:0] err_syn(input int q, input int a);
    logic [1:0] p;
    err_syn = '0;
    for (int i = 0; i < 4; i++) begin
      p = STAB[(3 - i) * 10 + (4 - q) * 2 +: 2];
      if (p != 2'b00 && p != 2'(a)) err_syn[3 - i] = 1'b1;
    end
  endfunction

  // returns {one-hot qubit, axis}; zero for the trivial syndrome
  function automatic logic [6:0] decode(input logic [3:0] s);
    decode = '0;
    for (int q = 0; q < 5; q++)
      for (int a = 1; a < 4; a++)
        if (s != 4'd0 && err_syn(q, a) == s)
          decode = {5'(1 << (4 - q)), 2'(a)};
  endfunction

  // LUT model: 0 normal, 1 all axes report, 2 all zero, 3 stuck axis 00
  int         lut_mode;
  logic [1:0] phase;
  logic [6:0] dec;

  initial phase = 2'd0;
  always @(posedge CLK) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;

  assign lut_axis = (lut_mode == 3) ? 2'b00 : phase + 2'd1;

  always_comb begin
    lut_correction = '0;
    dec = decode(lut_ancilla);
    if (lut_mode == 0 && lut_axis == dec[1:0]) lut_correction = dec[6:2];
    if (lut_mode == 1 && lut_axis != 2'b00) lut_correction = dec[6:2];
  end

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_round(input logic [3:0] s, input int hold,
                           output bit got, output logic [4:0] q,
                           output logic [1:0] ax, output int lat,
                           output int rd_at, output bit steady);
    int n;
    int h;
    got = 0; q = '0; ax = '0; lat = -1; rd_at = -1; steady = 1; h = hold;
    n = 0;
    while (!syn_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("accept_ready", syn_ready, 1);
    syn_valid = 1'b1;
    syn_data  = s;
    @(negedge CLK);
    syn_valid = 1'b0;
    n = 0;
    while (n < 60) begin
      if (cmd_valid) begin
        if (!got) begin
          got = 1; lat = n; q = cmd_qubit; ax = cmd_axis;
        end else if (cmd_qubit !== q || cmd_axis !== ax || syn_ready) begin
          steady = 0;
        end
        if (h > 0) begin
          cmd_ready = 1'b0;
          h--;
        end else begin
          cmd_ready = 1'b1;
        end
      end
      if (round_done) begin
        rd_at = n;
        break;
      end
      @(negedge CLK);
      n++;
    end
    cmd_ready = 1'b0;
    chk("round_done_seen", rd_at >= 0, 1);
  endtask

  typedef struct {
    logic [3:0] syn;
    int         hold;
    bit         cmd;
    logic [4:0] q;
    logic [1:0] ax;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got;
    bit         steady;
    bit         stale;
    logic [4:0] q;
    logic [1:0] ax;
    int         lat;
    int         rd_at;
    int         exp_rc;
    int         exp_cc;
    logic [3:0] s;
    int         hold;
    logic [6:0] exp;

    checks = 0; failures = 0;
    vecs[0] = '{4'b0001, 0,  1'b1, 5'b10000, 2'b01};
    vecs[1] = '{4'b1111, 0,  1'b1, 5'b00010, 2'b10};
    vecs[2] = '{4'b0100, 0,  1'b1, 5'b00001, 2'b11};
    vecs[3] = '{4'b0000, 0,  1'b0, 5'b00000, 2'b00};
    vecs[4] = '{4'b0110, 10, 1'b1, 5'b00010, 2'b01};

    RST = 1'b1; syn_valid = 1'b0; syn_data = '0; cmd_ready = 1'b0;
    lut_mode = 0;
    repeat (3) @(negedge CLK);
    chk("rst_syn_ready", syn_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_round_count", round_count, 0);
    chk("rst_corr_count", corr_count, 0);
    chk("rst_fault", fault, 0);
    chk("rst_round_done", round_done, 0);
    RST = 1'b0;
    @(negedge CLK);

    exp_rc = 0; exp_cc = 0;
    for (int i = 0; i < 5; i++) begin
      run_round(vecs[i].syn, vecs[i].hold, got, q, ax, lat, rd_at, steady);
      exp_rc++;
      if (vecs[i].cmd) exp_cc++;
      chk("vec_cmd_seen", got, vecs[i].cmd);
      if (vecs[i].cmd) begin
        chk("vec_qubit", q, vecs[i].q);
        chk("vec_axis", ax, vecs[i].ax);
        chk("vec_latency", lat, 6);
        chk("vec_done_at", rd_at, 7 + vecs[i].hold);
      end else begin
        chk("vec_done_at", rd_at, 6);
      end
      chk("vec_steady", steady, 1);
      chk("vec_round_count", round_count, exp_rc);
      chk("vec_corr_count", corr_count, exp_cc);
      chk("vec_fault", fault, 0);
    end

    // reset while capturing
    syn_valid = 1'b1; syn_data = 4'b0001;
    @(negedge CLK);
    syn_valid = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_syn_ready", syn_ready, 1);
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_round_done", round_done, 0);
    chk("midrst_ancilla", lut_ancilla, 0);
    chk("midrst_cmd", {cmd_qubit, cmd_axis}, 0);
    chk("midrst_counts", {round_count, corr_count}, 0);
    chk("midrst_fault", fault, 0);
    stale = 0;
    repeat (12) begin
      @(negedge CLK);
      if (cmd_valid || round_done) stale = 1;
    end
    chk("midrst_no_stale", stale, 0);
    exp_rc = 0; exp_cc = 0;

    // LUT stuck on axis 00: capture timeout
    lut_mode = 3;
    run_round(4'b0001, 0, got, q, ax, lat, rd_at, steady);
    exp_rc++;
    chk("stuck_no_cmd", got, 0);
    chk("stuck_done_at", rd_at, 8);
    chk("stuck_fault", fault, 1);
    @(negedge CLK);
    chk("stuck_done_pulse", round_done, 0);
    lut_mode = 0;
    run_round(4'b0110, 0, got, q, ax, lat, rd_at, steady);
    exp_rc++; exp_cc++;
    chk("after_stuck_qubit", q, 5'b00010);
    chk("fault_sticky", fault, 1);
    lut_mode = 1;
    run_round(4'b1111, 0, got, q, ax, lat, rd_at, steady);
    exp_rc++;
    chk("multi_no_cmd", got, 0);
    chk("multi_done_at", rd_at, 6);
    lut_mode = 2;
    run_round(4'b0100, 0, got, q, ax, lat, rd_at, steady);
    exp_rc++;
    chk("zero_no_cmd", got, 0);
    chk("zero_done_at", rd_at, 6);
    chk("fault_counts", {round_count, corr_count}, {16'(exp_rc), 16'(exp_cc)});
    lut_mode = 0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("fault_cleared", fault, 0);
    exp_rc = 0; exp_cc = 0;

    for (int i = 0; i < 40; i++) begin
      s    = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      exp  = decode(s);
      run_round(s, hold, got, q, ax, lat, rd_at, steady);
      exp_rc++;
      chk("rnd_cmd_seen", got, s != 4'd0);
      if (s != 4'd0) begin
        exp_cc++;
        chk("rnd_qubit", q, exp[6:2]);
        chk("rnd_axis", ax, exp[1:0]);
        chk("rnd_latency", lat, 6);
        chk("rnd_done_at", rd_at, 7 + hold);
      end else begin
        chk("rnd_done_at", rd_at, 6);
      end
      chk("rnd_steady", steady, 1);
      chk("rnd_round_count", round_count, exp_rc & 32'hFFFF);
      chk("rnd_corr_count", corr_count, exp_cc & 32'hFFFF);
      chk("rnd_fault", fault, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
